// File: rtl/logic_gates_pkg.sv
// Shared constants and gate-index enumeration for the logic_gates block.
// The gate index orders the packed result vector used by the core.
package logic_gates_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;
    localparam int unsigned NUM_GATES     = 7;

    typedef enum logic [2:0] {
        GATE_AND  = 3'd0,
        GATE_NAND = 3'd1,
        GATE_OR   = 3'd2,
        GATE_NOR  = 3'd3,
        GATE_XOR  = 3'd4,
        GATE_XNOR = 3'd5,
        GATE_NOT  = 3'd6
    } gate_e;

    // Single-bit evaluation of one gate; NOT ignores b by definition.
    function automatic logic gate_eval(input gate_e g, input logic a, input logic b);
        logic r;
        r = 1'b0;
        case (g)
            GATE_AND:  r = a & b;
            GATE_NAND: r = ~(a & b);
            GATE_OR:   r = a | b;
            GATE_NOR:  r = ~(a | b);
            GATE_XOR:  r = a ^ b;
            GATE_XNOR: r = ~(a ^ b);
            GATE_NOT:  r = ~a;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_gates_core.sv
// Unregistered seven-function bitwise evaluation of A and B.
// Each output bit depends only on the matching bit of A and B.
module logic_gates_core
    import logic_gates_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] and_Y,
    output logic [WIDTH-1:0] nand_Y,
    output logic [WIDTH-1:0] or_Y,
    output logic [WIDTH-1:0] nor_Y,
    output logic [WIDTH-1:0] xor_Y,
    output logic [WIDTH-1:0] xnor_Y,
    output logic [WIDTH-1:0] not_Y
);

    always_comb begin
        and_Y  = '0;
        nand_Y = '0;
        or_Y   = '0;
        nor_Y  = '0;
        xor_Y  = '0;
        xnor_Y = '0;
        not_Y  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            and_Y[i]  = gate_eval(GATE_AND,  A[i], B[i]);
            nand_Y[i] = gate_eval(GATE_NAND, A[i], B[i]);
            or_Y[i]   = gate_eval(GATE_OR,   A[i], B[i]);
            nor_Y[i]  = gate_eval(GATE_NOR,  A[i], B[i]);
            xor_Y[i]  = gate_eval(GATE_XOR,  A[i], B[i]);
            xnor_Y[i] = gate_eval(GATE_XNOR, A[i], B[i]);
            not_Y[i]  = gate_eval(GATE_NOT,  A[i], B[i]);
        end
    end

endmodule

// File: rtl/logic_gates.sv
// Registered bitwise gate bank: one-cycle latency, synchronous active-high reset.
// All seven outputs come straight from flops and update on the same edge.
module logic_gates
    import logic_gates_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] and_Y,
    output logic [WIDTH-1:0] nand_Y,
    output logic [WIDTH-1:0] or_Y,
    output logic [WIDTH-1:0] nor_Y,
    output logic [WIDTH-1:0] xor_Y,
    output logic [WIDTH-1:0] xnor_Y,
    output logic [WIDTH-1:0] not_Y
);

    logic [WIDTH-1:0] and_c;
    logic [WIDTH-1:0] nand_c;
    logic [WIDTH-1:0] or_c;
    logic [WIDTH-1:0] nor_c;
    logic [WIDTH-1:0] xor_c;
    logic [WIDTH-1:0] xnor_c;
    logic [WIDTH-1:0] not_c;

    logic_gates_core #(
        .WIDTH(WIDTH)
    ) core (
        .A      (A),
        .B      (B),
        .and_Y  (and_c),
        .nand_Y (nand_c),
        .or_Y   (or_c),
        .nor_Y  (nor_c),
        .xor_Y  (xor_c),
        .xnor_Y (xnor_c),
        .not_Y  (not_c)
    );

    // Reset forces every output to zero, including the complement outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            and_Y  <= '0;
            nand_Y <= '0;
            or_Y   <= '0;
            nor_Y  <= '0;
            xor_Y  <= '0;
            xnor_Y <= '0;
            not_Y  <= '0;
        end else begin
            and_Y  <= and_c;
            nand_Y <= nand_c;
            or_Y   <= or_c;
            nor_Y  <= nor_c;
            xor_Y  <= xor_c;
            xnor_Y <= xnor_c;
            not_Y  <= not_c;
        end
    end

endmodule

// File: tb/tb_logic_gates.sv
// Scoreboard bench for logic_gates: 1-bit default build and a 4-bit build
// share clock and reset; expected results are queued at drive time.
module tb_logic_gates;
    import logic_gates_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       A, B;
    logic [3:0] A4, B4;

    logic and_y, nand_y, or_y, nor_y, xor_y, xnor_y, not_y;
    logic [3:0] and4, nand4, or4, nor4, xor4, xnor4, not4;

    logic [6:0]  exp1_q[$];
    logic [27:0] exp4_q[$];
    logic [6:0]  got1, exp1;
    logic [27:0] got4, exp4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    logic_gates dut (
        .clk(clk), .rst(rst), .A(A), .B(B),
        .and_Y(and_y), .nand_Y(nand_y), .or_Y(or_y), .nor_Y(nor_y),
        .xor_Y(xor_y), .xnor_Y(xnor_y), .not_Y(not_y)
    );

    logic_gates #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .A(A4), .B(B4),
        .and_Y(and4), .nand_Y(nand4), .or_Y(or4), .nor_Y(nor4),
        .xor_Y(xor4), .xnor_Y(xnor4), .not_Y(not4)
    );

    assign got1 = {and_y, nand_y, or_y, nor_y, xor_y, xnor_y, not_y};
    assign got4 = {and4, nand4, or4, nor4, xor4, xnor4, not4};

    // Truth-table model, independent of the package helper.
    function automatic logic [6:0] model1(input logic a, input logic b);
        logic [3:0] tt_and  = 4'b1000;
        logic [3:0] tt_or   = 4'b1110;
        logic [3:0] tt_xor  = 4'b0110;
        logic [1:0] idx;
        idx = {a, b};
        return {tt_and[idx], ~tt_and[idx], tt_or[idx], ~tt_or[idx],
                tt_xor[idx], ~tt_xor[idx], ~a};
    endfunction

    function automatic logic [27:0] model4(input logic [3:0] a, input logic [3:0] b);
        logic [6:0]  m;
        logic [27:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            m = model1(a[i], b[i]);
            for (int g = 0; g < 7; g++) r[g*4 + i] = m[g];
        end
        return r;
    endfunction

    // Drive one cycle on both DUTs, queue expectations, then check after the edge.
    task automatic step(input string name, input logic r, input logic a, input logic b,
                        input logic [3:0] a4, input logic [3:0] b4);
        @(negedge clk);
        rst = r; A = a; B = b; A4 = a4; B4 = b4;
        exp1_q.push_back(r ? 7'd0 : model1(a, b));
        exp4_q.push_back(r ? 28'd0 : model4(a4, b4));
        @(posedge clk);
        #1;
        exp1 = exp1_q.pop_front();
        exp4 = exp4_q.pop_front();
        vectors++;
        if (got1 !== exp1) begin
            miscompares++;
            $display("FAIL %s w1: got %b expected %b", name, got1, exp1);
        end
        vectors++;
        if (got4 !== exp4) begin
            miscompares++;
            $display("FAIL %s w4: got %h expected %h", name, got4, exp4);
        end
    endtask

    task automatic test_reset();
        step("reset0", 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
        step("reset1", 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
    endtask

    task automatic test_truth_table();
        step("tt00", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        step("tt01", 1'b0, 1'b0, 1'b1, 4'h0, 4'hF);
        step("tt10", 1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
        step("tt11", 1'b0, 1'b1, 1'b1, 4'hF, 4'hF);
    endtask

    task automatic test_wide();
        step("wide_c_a", 1'b0, 1'b1, 1'b0, 4'b1100, 4'b1010);
        vectors++;
        if ({and4, nand4, or4, nor4, xor4, xnor4, not4} !==
            {4'b1000, 4'b0111, 4'b1110, 4'b0001, 4'b0110, 4'b1001, 4'b0011}) begin
            miscompares++;
            $display("FAIL wide_const: got %h expected %h", got4,
                     {4'b1000, 4'b0111, 4'b1110, 4'b0001, 4'b0110, 4'b1001, 4'b0011});
        end
    endtask

    task automatic test_latency();
        step("lat_base", 1'b0, 1'b1, 1'b1, 4'h5, 4'h3);
        #2;
        A = 1'b0; B = 1'b0; A4 = 4'hA; B4 = 4'h6;
        #1;
        vectors++;
        if (got1 !== model1(1'b1, 1'b1)) begin
            miscompares++;
            $display("FAIL lat_hold w1: got %b expected %b", got1, model1(1'b1, 1'b1));
        end
        vectors++;
        if (got4 !== model4(4'h5, 4'h3)) begin
            miscompares++;
            $display("FAIL lat_hold w4: got %h expected %h", got4, model4(4'h5, 4'h3));
        end
        @(posedge clk);
        #1;
        vectors++;
        if (got1 !== model1(1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL lat_next w1: got %b expected %b", got1, model1(1'b0, 1'b0));
        end
        vectors++;
        if (got4 !== model4(4'hA, 4'h6)) begin
            miscompares++;
            $display("FAIL lat_next w4: got %h expected %h", got4, model4(4'hA, 4'h6));
        end
    endtask

    task automatic test_reset_pulse();
        step("pulse_pre",  1'b0, 1'b1, 1'b1, 4'h9, 4'hC);
        step("pulse_rst",  1'b1, 1'b1, 1'b1, 4'h9, 4'hC);
        step("pulse_post", 1'b0, 1'b1, 1'b1, 4'h9, 4'hC);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            logic [3:0] ra, rb;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            step("b2b", (n % 13) == 12, ra[0], rb[0], ra, rb);
        end
    endtask

    initial begin
        rst = 1'b1; A = 1'b1; B = 1'b1; A4 = '1; B4 = '1;
        test_reset();
        test_truth_table();
        test_wide();
        test_latency();
        test_reset_pulse();
        test_back_to_back();
        vectors++;
        if (exp1_q.size() != 0 || exp4_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d/%0d left expected 0",
                     exp1_q.size(), exp4_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
